// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg: shared types and helpers for the modulo-N counter.
// Configuration macro: MOD_COUNTER_DIR_EN (enables down counting in users of this package).
package mod_counter_pkg;

  // Per-edge command after priority resolution (CLR > LOAD > EN > hold).
  typedef enum logic [1:0] {
    CMD_HOLD = 2'd0,
    CMD_CLR  = 2'd1,
    CMD_LOAD = 2'd2,
    CMD_STEP = 2'd3
  } cmd_e;

  // Resolve the synchronous controls into a single command.
  function automatic cmd_e decode_cmd(input logic clr, input logic load, input logic en);
    if (clr)       return CMD_CLR;
    else if (load) return CMD_LOAD;
    else if (en)   return CMD_STEP;
    else           return CMD_HOLD;
  endfunction

  // Out-of-range loads clamp to the top of the count range.
  function automatic logic [31:0] sat_load(input logic [31:0] val, input logic [31:0] modulus);
    return (val >= modulus) ? (modulus - 32'd1) : val;
  endfunction

  // Legal configurations: 2 <= MODULUS <= 2**WIDTH, RESET_VALUE inside the range.
  function automatic bit params_ok(input int width, input int modulus, input int reset_value);
    return (width >= 1) && (width <= 31) && (modulus >= 2) &&
           (modulus <= (1 << width)) && (reset_value >= 0) && (reset_value < modulus);
  endfunction

endpackage

// File: rtl/mod_counter_next.sv
// mod_counter_next: combinational next count and wrap flag for mod_counter.
// Configuration macro: MOD_COUNTER_DIR_EN (adds the down-count path; otherwise up only).
module mod_counter_next
  import mod_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic [WIDTH-1:0] cur,
  input  cmd_e             cmd,
  input  logic             up,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);

  // Explicit top-of-range compare, so MODULUS == 2**WIDTH behaves like any other modulus.
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

`ifndef MOD_COUNTER_DIR_EN
  // Direction input is kept for pin compatibility but has no effect.
  logic unused_up;
  assign unused_up = up;
`endif

  // Next-state arithmetic for the resolved command; wrap only on a counting rollover.
  always_comb begin
    nxt  = cur;
    wrap = 1'b0;
    unique case (cmd)
      CMD_CLR:  nxt = '0;
      CMD_LOAD: nxt = WIDTH'(sat_load(32'(load_val), 32'(MODULUS)));
      CMD_STEP: begin
`ifdef MOD_COUNTER_DIR_EN
        if (!up) begin
          if (cur == '0) begin
            nxt  = MAX;
            wrap = 1'b1;
          end else begin
            nxt = cur - WIDTH'(1);
          end
        end else
`endif
        if (cur == MAX) begin
          nxt  = '0;
          wrap = 1'b1;
        end else begin
          nxt = cur + WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mod_counter.sv
// mod_counter: parametrised modulo-N counter with enable, load, clear and cascade TC.
// Configuration macro: MOD_COUNTER_DIR_EN (UP selects direction; undefined = up only).
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int MODULUS     = 10,
  parameter int RESET_VALUE = 0
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             EN,
  input  logic             UP,
  output logic [WIDTH-1:0] OUT,
  output logic             TC,
  output logic             WRAP
);

  if (!params_ok(WIDTH, MODULUS, RESET_VALUE)) begin : g_bad_params
    $fatal(1, "mod_counter: illegal WIDTH/MODULUS/RESET_VALUE combination");
  end

  localparam logic [WIDTH-1:0] MAX     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

  cmd_e             cmd;
  logic [WIDTH-1:0] nxt;
  logic             nxt_wrap;
  logic             at_term;

  assign cmd = decode_cmd(CLR, LOAD, EN);

  mod_counter_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .cur      (OUT),
    .cmd      (cmd),
    .up       (UP),
    .load_val (LOAD_VAL),
    .nxt      (nxt),
    .wrap     (nxt_wrap)
  );

  // Reset asserts asynchronously; the first edge with RESET_N high already counts.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      OUT  <= RST_VAL;
      WRAP <= 1'b0;
    end else begin
      OUT  <= nxt;
      WRAP <= nxt_wrap;
    end
  end

`ifdef MOD_COUNTER_DIR_EN
  assign at_term = UP ? (OUT == MAX) : (OUT == '0);
`else
  assign at_term = (OUT == MAX);
`endif

  // Zero-latency terminal count so a following stage steps on the same edge as the wrap.
  assign TC = EN & ~CLR & ~LOAD & at_term;

endmodule

// File: tb/tb_mod_counter.sv
// tb_mod_counter: directed bench with a behavioural model for mod_counter.
module tb_mod_counter;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b1;
  logic       CLR = 1'b0, LOAD = 1'b0, EN = 1'b0, UP = 1'b1;
  logic [3:0] LOAD_VAL = '0;
  logic       cas_en = 1'b0;

  logic [3:0] out10, out16, lo_out, hi_out;
  logic       tc10, tc16, lo_tc, hi_tc;
  logic       wrap10, wrap16, lo_wrap, hi_wrap;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) dut10 (
    .CLK(CLK), .RESET_N(RESET_N), .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .EN(EN), .UP(UP), .OUT(out10), .TC(tc10), .WRAP(wrap10));

  mod_counter #(.WIDTH(4), .MODULUS(16), .RESET_VALUE(3)) dut16 (
    .CLK(CLK), .RESET_N(RESET_N), .CLR(CLR), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .EN(EN), .UP(UP), .OUT(out16), .TC(tc16), .WRAP(wrap16));

  mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_lo (
    .CLK(CLK), .RESET_N(RESET_N), .CLR(1'b0), .LOAD(1'b0), .LOAD_VAL(4'd0),
    .EN(cas_en), .UP(1'b1), .OUT(lo_out), .TC(lo_tc), .WRAP(lo_wrap));

  mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VALUE(0)) u_hi (
    .CLK(CLK), .RESET_N(RESET_N), .CLR(1'b0), .LOAD(1'b0), .LOAD_VAL(4'd0),
    .EN(lo_tc), .UP(1'b1), .OUT(hi_out), .TC(hi_tc), .WRAP(hi_wrap));

  // Effective direction seen by the counters in this build.
  bit up_eff;
`ifdef MOD_COUNTER_DIR_EN
  assign up_eff = UP;
`else
  assign up_eff = 1'b1;
`endif

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: count range 0..M-1 as plain integer arithmetic.
  function automatic void mstep(input int m, input int M, input bit clr, input bit load,
                                input bit en, input bit up, input int lv,
                                output int nm, output bit nw);
    nm = m;
    nw = 1'b0;
    if (clr) nm = 0;
    else if (load) nm = (lv < M) ? lv : M - 1;
    else if (en) begin
      if (up) begin nm = (m + 1) % M; nw = (m + 1 == M); end
      else    begin nm = (m + M - 1) % M; nw = (m == 0); end
    end
  endfunction

  function automatic bit mtc(input int m, input int M, input bit clr, input bit load,
                             input bit en, input bit up);
    return en && !clr && !load && (up ? (m == M - 1) : (m == 0));
  endfunction

  int m10 = 0, m16 = 3;
  bit w10 = 0, w16 = 0;
  bit chk_en = 0;

  always @(posedge CLK or negedge RESET_N) begin
    int n10, n16;
    bit x10, x16;
    if (!RESET_N) begin
      m10 = 0; w10 = 0; m16 = 3; w16 = 0;
    end else begin
      mstep(m10, 10, CLR, LOAD, EN, up_eff, int'(LOAD_VAL), n10, x10);
      mstep(m16, 16, CLR, LOAD, EN, up_eff, int'(LOAD_VAL), n16, x16);
      m10 = n10; w10 = x10; m16 = n16; w16 = x16;
    end
  end

  // Every cycle, compare both standalone counters against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      chk("out10", int'(out10), m10);
      chk("wrap10", int'(wrap10), int'(w10));
      chk("tc10", int'(tc10), int'(mtc(m10, 10, CLR, LOAD, EN, up_eff)));
      chk("out16", int'(out16), m16);
      chk("wrap16", int'(wrap16), int'(w16));
      chk("tc16", int'(tc16), int'(mtc(m16, 16, CLR, LOAD, EN, up_eff)));
    end
  end

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    int lo_wraps, hi_wraps;
    // Reset state
    #3 RESET_N = 1'b0;
    #1;
    chk("rst_out10", int'(out10), 0);
    chk("rst_out16", int'(out16), 3);
    chk("rst_wrap10", int'(wrap10), 0);
    chk_en = 1'b1;
    tick; tick;
    RESET_N = 1'b1;

    // Up count with wrap: 1..9,0,1,2
    EN = 1'b1; UP = 1'b1;
    #1 chk("up_tc_at0", int'(tc10), 0);
    for (int i = 1; i <= 12; i++) begin
      tick;
      chk("up_out", int'(out10), i % 10);
      chk("up_wrap", int'(wrap10), (i == 10) ? 1 : 0);
      chk("up_tc", int'(tc10), (i == 9) ? 1 : 0);
    end

    // Reset mid-count at 6, no clock edge needed
    repeat (4) tick;
    chk("pre_rst_out", int'(out10), 6);
    RESET_N = 1'b0;
    #1;
    chk("midrst_out", int'(out10), 0);
    chk("midrst_wrap", int'(wrap10), 0);
    tick;
    RESET_N = 1'b1;
    // Reset during a WRAP pulse drops it
    repeat (10) tick;
    chk("wrap_before_rst", int'(wrap10), 1);
    RESET_N = 1'b0;
    #1;
    chk("wrap_drop_rst", int'(wrap10), 0);
    tick;
    RESET_N = 1'b1;

    // Direction
    EN = 1'b0; LOAD = 1'b1; LOAD_VAL = 4'd1;
    tick;
    LOAD = 1'b0; EN = 1'b1; UP = 1'b0;
`ifdef MOD_COUNTER_DIR_EN
    #1 chk("dn_tc_at1", int'(tc10), 0);
    tick;
    chk("dn_out0", int'(out10), 0);
    chk("dn_tc_at0", int'(tc10), 1);
    tick;
    chk("dn_out9", int'(out10), 9);
    chk("dn_wrap", int'(wrap10), 1);
    tick;
    chk("dn_out8", int'(out10), 8);
    chk("dn_wrap_end", int'(wrap10), 0);
`else
    tick;
    chk("uponly_out2", int'(out10), 2);
    tick;
    chk("uponly_out3", int'(out10), 3);
`endif

    // Loads, saturation, LOAD beats EN
    EN = 1'b0; UP = 1'b1; LOAD = 1'b1; LOAD_VAL = 4'd7;
    tick;
    chk("load7", int'(out10), 7);
    LOAD_VAL = 4'd13;
    tick;
    chk("load_sat", int'(out10), 9);
    chk("load_sat16", int'(out16), 13);
    EN = 1'b1; LOAD_VAL = 4'd4;
    tick;
    chk("load_en", int'(out10), 4);
    LOAD_VAL = 4'd9;
    tick;
    chk("load9", int'(out10), 9);
    chk("tc_masked_load", int'(tc10), 0);

    // Priority: CLR over LOAD and EN at the top of range
    CLR = 1'b1;
    #1 chk("tc_masked_clr", int'(tc10), 0);
    tick;
    chk("clr_out", int'(out10), 0);
    chk("clr_wrap", int'(wrap10), 0);
    CLR = 1'b0; EN = 1'b0; LOAD_VAL = 4'd5;
    tick;
    chk("load5", int'(out10), 5);
    LOAD = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("hold", int'(out10), 5);
    end

    // Full-range modulus wraps 15 -> 0
    LOAD = 1'b1; LOAD_VAL = 4'd15;
    tick;
    LOAD = 1'b0; EN = 1'b1;
    tick;
    chk("m16_wrap_out", int'(out16), 0);
    chk("m16_wrap", int'(wrap16), 1);
    EN = 1'b0;

    // Cascade two decade counters through TC
    RESET_N = 1'b0;
    tick;
    RESET_N = 1'b1;
    cas_en = 1'b1;
    lo_wraps = 0; hi_wraps = 0;
    for (int k = 1; k <= 100; k++) begin
      tick;
      chk("cascade", int'(hi_out) * 10 + int'(lo_out), k % 100);
      if (k == 99) chk("hi_tc", int'(hi_tc), 1);
      lo_wraps += int'(lo_wrap);
      hi_wraps += int'(hi_wrap);
    end
    chk("lo_wraps", lo_wraps, 10);
    chk("hi_wraps", hi_wraps, 1);
    cas_en = 1'b0;
    tick;

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
